// File: rtl/serial_mem_responder_pkg.sv
// sermem_pkg: shared state encoding, access-size codes and alignment helper
// for the bit-serial memory responder.
package sermem_pkg;

  localparam int WORD_BITS = 32;

  localparam logic [1:0] FUNC_B = 2'b00;
  localparam logic [1:0] FUNC_H = 2'b01;
  localparam logic [1:0] FUNC_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    MEM,
    LATCH,
    RDATA
  } state_t;

  // Size code 2'b11 falls into the default branch and is checked as a word.
  function automatic logic misaligned_access(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      FUNC_B:  return 1'b0;
      FUNC_H:  return lsb[0];
      default: return |lsb;
    endcase
  endfunction

endpackage

// File: rtl/serial_mem_responder_if.sv
// serial_mem_responder_if: serial request lines from the core plus the
// 32-bit word RAM port, bundled for the responder.
interface serial_mem_responder_if #(
  parameter int ADDR_BITS = 12
);
  logic                 req_valid;
  logic                 req_write;
  logic [2:0]           req_func;
  logic                 ser_in;
  logic                 ser_out;
  logic                 ser_out_valid;
  logic                 done;
  logic                 misaligned;
  logic [ADDR_BITS-3:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wstrb;
  logic                 mem_we;
  logic [31:0]          mem_rdata;

  modport master (
    output req_valid, req_write, req_func, ser_in, mem_rdata,
    input  ser_out, ser_out_valid, done, misaligned,
           mem_addr, mem_wdata, mem_wstrb, mem_we
  );

  modport slave (
    input  req_valid, req_write, req_func, ser_in, mem_rdata,
    output ser_out, ser_out_valid, done, misaligned,
           mem_addr, mem_wdata, mem_wstrb, mem_we
  );

endinterface

// File: rtl/sermem_lane_align.sv
// sermem_lane_align: places store data on byte lanes and extracts/extends
// load data for byte, half and word accesses. Purely combinational.
module sermem_lane_align
  import sermem_pkg::*;
(
  input  logic [1:0]           addr_lo,
  input  logic [2:0]           func,
  input  logic [WORD_BITS-1:0] store_data,
  input  logic [WORD_BITS-1:0] load_data,
  output logic [WORD_BITS-1:0] wdata,
  output logic [3:0]           wstrb,
  output logic [WORD_BITS-1:0] rdata_ext
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        ext;

  // Half accesses only look at addr[1], so odd half addresses round down.
  always_comb begin
    sel_byte  = load_data[7:0];
    sel_half  = addr_lo[1] ? load_data[31:16] : load_data[15:0];
    wdata     = '0;
    wstrb     = '0;
    rdata_ext = load_data;
    ext       = 1'b0;

    case (addr_lo)
      2'd1:    sel_byte = load_data[15:8];
      2'd2:    sel_byte = load_data[23:16];
      2'd3:    sel_byte = load_data[31:24];
      default: sel_byte = load_data[7:0];
    endcase

    case (func[1:0])
      FUNC_B: begin
        wdata     = {24'h0, store_data[7:0]} << {addr_lo, 3'b000};
        wstrb     = 4'b0001 << addr_lo;
        ext       = ~func[2] & sel_byte[7];
        rdata_ext = {{24{ext}}, sel_byte};
      end
      FUNC_H: begin
        wdata     = addr_lo[1] ? {store_data[15:0], 16'h0} : {16'h0, store_data[15:0]};
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        ext       = ~func[2] & sel_half[15];
        rdata_ext = {{16{ext}}, sel_half};
      end
      default: begin
        wdata     = store_data;
        wstrb     = 4'b1111;
        rdata_ext = load_data;
      end
    endcase
  end

endmodule

// File: rtl/serial_mem_responder.sv
// serial_mem_responder: bit-serial load/store link to a 32-bit word RAM.
// Define SERMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of rounding them down.
module serial_mem_responder
  import sermem_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_mem_responder_if.slave bus
);

  localparam int         IDX_BITS  = $clog2(ADDR_BITS);
  localparam logic [5:0] ADDR_LAST = 6'(ADDR_BITS - 1);
  localparam logic [5:0] WORD_LAST = 6'(WORD_BITS - 1);

  state_t               state, state_d;
  logic [5:0]           cnt, cnt_d;
  logic                 write_r;
  logic [2:0]           func_r;
  logic [ADDR_BITS-2:0] addr_r;
  logic [ADDR_BITS-3:0] mem_addr_r;
  logic [WORD_BITS-1:0] store_r, shift_r;
  logic                 misaligned_r, misaligned_d;
  logic                 fault;
  logic [WORD_BITS-1:0] lane_wdata, lane_rdata;
  logic [3:0]           lane_wstrb;
  logic                 ser_out, ser_out_valid, done, mem_we;
  logic [WORD_BITS-1:0] mem_wdata;
  logic [3:0]           mem_wstrb;

  sermem_lane_align u_lane_align (
    .addr_lo   (addr_r[1:0]),
    .func      (func_r),
    .store_data(store_r),
    .load_data (bus.mem_rdata),
    .wdata     (lane_wdata),
    .wstrb     (lane_wstrb),
    .rdata_ext (lane_rdata)
  );

`ifdef SERMEM_MISALIGN_TRAP_EN
  assign fault          = misaligned_access(func_r[1:0], addr_r[1:0]);
  assign bus.misaligned = misaligned_r;
`else
  assign fault          = 1'b0;
  assign bus.misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      misaligned_r <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      misaligned_r <= misaligned_d;
    end
  end

  // The fault flag is captured on the way into MEM so it is visible in that cycle.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    misaligned_d  = misaligned_r;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    done          = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    mem_wstrb     = '0;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_d      = ADDR;
          cnt_d        = '0;
          misaligned_d = 1'b0;
        end
      end
      ADDR: begin
        if (cnt == ADDR_LAST) begin
          cnt_d = '0;
          if (write_r) begin
            state_d = WDATA;
          end else begin
            state_d      = MEM;
            misaligned_d = fault;
          end
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      WDATA: begin
        if (cnt == WORD_LAST) begin
          cnt_d        = '0;
          state_d      = MEM;
          misaligned_d = fault;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      MEM: begin
        if (misaligned_r) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (write_r) begin
          mem_we    = 1'b1;
          mem_wdata = lane_wdata;
          mem_wstrb = lane_wstrb;
          done      = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        cnt_d   = '0;
        state_d = RDATA;
      end
      RDATA: begin
        ser_out       = shift_r[0];
        ser_out_valid = 1'b1;
        if (cnt == WORD_LAST) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The top address bit goes straight into mem_addr, so addr_r never holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_r    <= 1'b0;
      func_r     <= '0;
      addr_r     <= '0;
      mem_addr_r <= '0;
      store_r    <= '0;
      shift_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_r <= bus.req_write;
            func_r  <= bus.req_func;
          end
        end
        ADDR: begin
          if (cnt == ADDR_LAST)
            mem_addr_r <= {bus.ser_in, addr_r[ADDR_BITS-2:2]};
          else
            addr_r[cnt[IDX_BITS-1:0]] <= bus.ser_in;
        end
        WDATA: store_r[cnt[4:0]] <= bus.ser_in;
        LATCH: shift_r <= lane_rdata;
        RDATA: shift_r <= {1'b0, shift_r[WORD_BITS-1:1]};
        default: ;
      endcase
    end
  end

  assign bus.ser_out       = ser_out;
  assign bus.ser_out_valid = ser_out_valid;
  assign bus.done          = done;
  assign bus.mem_we        = mem_we;
  assign bus.mem_wdata     = mem_wdata;
  assign bus.mem_wstrb     = mem_wstrb;
  assign bus.mem_addr      = mem_addr_r;

endmodule

// File: tb/tb_serial_mem_responder.sv
// tb_serial_mem_responder: directed and randomized transactions against a
// byte-level reference memory; honours SERMEM_MISALIGN_TRAP_EN like the DUT.
module tb_serial_mem_responder;
  import sermem_pkg::*;

`ifdef SERMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [0:1023];
  logic [31:0] ram     [0:1023];

  serial_mem_responder_if #(.ADDR_BITS(12)) bus ();

  serial_mem_responder #(.ADDR_BITS(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Synchronous word RAM: read data appears one cycle after the address.
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      bus.mem_rdata <= ram[bus.mem_addr];
      if (bus.mem_we === 1'b1)
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) ram[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, ".ser_out"},       32'(bus.ser_out),       32'h0);
    check_output({tag, ".ser_out_valid"}, 32'(bus.ser_out_valid), 32'h0);
    check_output({tag, ".done"},          32'(bus.done),          32'h0);
    check_output({tag, ".misaligned"},    32'(bus.misaligned),    32'h0);
    check_output({tag, ".mem_we"},        32'(bus.mem_we),        32'h0);
    check_output({tag, ".mem_wstrb"},     32'(bus.mem_wstrb),     32'h0);
    check_output({tag, ".mem_wdata"},     bus.mem_wdata,          32'h0);
    check_output({tag, ".mem_addr"},      32'(bus.mem_addr),      32'h0);
  endtask

  // One full transaction over 50 cycles; cycle c is observed at its falling edge.
  task automatic apply_stimulus(input string tag, input bit wr, input logic [2:0] func,
                                input logic [11:0] addr, input logic [31:0] data);
    int          sz, ofs, lane, wa, done_cyc, done_cnt, we_cnt, valid_cnt, first_valid;
    bit          flt;
    logic [31:0] word, exp_wd, exp_val, got_val, wd_at_done;
    logic [3:0]  exp_strb, strb_at_done;
    logic [9:0]  addr_at_done;
    logic        mis_at_done, mis_at1, we_at_done;

    sz   = (func[1:0] == 2'b00) ? 1 : (func[1:0] == 2'b01) ? 2 : 4;
    ofs  = int'(addr) % sz;
    flt  = TRAP && (ofs != 0);
    lane = (int'(addr) - ofs) % 4;
    wa   = int'(addr) / 4;
    word = ref_mem[wa];

    exp_wd   = '0;
    exp_strb = '0;
    exp_val  = '0;
    for (int i = 0; i < sz; i++) begin
      exp_strb[lane+i]        = 1'b1;
      exp_wd[8*(lane+i) +: 8] = data[8*i +: 8];
      exp_val[8*i +: 8]       = word[8*(lane+i) +: 8];
    end
    if (!func[2] && sz < 4 && exp_val[8*sz-1])
      for (int j = sz; j < 4; j++) exp_val[8*j +: 8] = 8'hFF;
    if (flt) begin
      exp_wd   = '0;
      exp_strb = '0;
    end

    done_cyc = -1; done_cnt = 0; we_cnt = 0; valid_cnt = 0; first_valid = -1;
    got_val = '0; wd_at_done = '0; strb_at_done = '0; addr_at_done = '0;
    mis_at_done = 1'bx; mis_at1 = 1'bx; we_at_done = 1'bx;

    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 1) mis_at1 = bus.misaligned;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = c;
          mis_at_done  = bus.misaligned;
          we_at_done   = bus.mem_we;
          strb_at_done = bus.mem_wstrb;
          wd_at_done   = bus.mem_wdata;
          addr_at_done = bus.mem_addr;
        end
      end
      if (bus.mem_we === 1'b1) we_cnt++;
      if (bus.ser_out_valid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        if (valid_cnt < 32) got_val[valid_cnt] = bus.ser_out;
        valid_cnt++;
      end
      bus.req_valid = (c == 0) ? 1'b1 : (c <= 12) ? 1'($urandom) : 1'b0;
      bus.req_write = (c == 0) ? wr : 1'($urandom);
      bus.req_func  = (c == 0) ? func : 3'($urandom);
      if (c >= 1 && c <= 12)             bus.ser_in = addr[c-1];
      else if (wr && c >= 13 && c <= 44) bus.ser_in = data[c-13];
      else                               bus.ser_in = 1'($urandom);
    end

    check_output({tag, ".done_cycle"}, 32'(done_cyc), (!wr && flt) ? 32'd13 : wr ? 32'd45 : 32'd46);
    check_output({tag, ".done_count"}, 32'(done_cnt), 32'd1);
    check_output({tag, ".misaligned_at_done"}, 32'(mis_at_done), 32'(flt));
    check_output({tag, ".misaligned_held"}, 32'(bus.misaligned), 32'(flt));
    check_output({tag, ".misaligned_cleared"}, 32'(mis_at1), 32'h0);
    check_output({tag, ".mem_addr"}, 32'(addr_at_done), 32'(wa));
    if (wr) begin
      check_output({tag, ".we_at_done"}, 32'(we_at_done), 32'(!flt));
      check_output({tag, ".we_count"}, 32'(we_cnt), flt ? 32'd0 : 32'd1);
      check_output({tag, ".wstrb"}, 32'(strb_at_done), 32'(exp_strb));
      check_output({tag, ".wdata"}, wd_at_done, exp_wd);
      check_output({tag, ".valid_count"}, 32'(valid_cnt), 32'd0);
      if (!flt)
        for (int i = 0; i < sz; i++) ref_mem[wa][8*(lane+i) +: 8] = data[8*i +: 8];
    end else begin
      check_output({tag, ".we_count"}, 32'(we_cnt), 32'd0);
      check_output({tag, ".valid_count"}, 32'(valid_cnt), flt ? 32'd0 : 32'd32);
      if (!flt) begin
        check_output({tag, ".first_valid"}, 32'(first_valid), 32'd15);
        check_output({tag, ".load_data"}, got_val, exp_val);
      end
    end
  endtask

  // Reset lands in the middle of the store-data phase; nothing may be written.
  task automatic apply_reset_mid_store(input logic [11:0] addr, input logic [31:0] data);
    int we_cnt;
    we_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.req_valid = (c == 0);
      bus.req_write = 1'b1;
      bus.req_func  = 3'b010;
      if (c >= 1 && c <= 12) bus.ser_in = addr[c-1];
      else if (c >= 13)      bus.ser_in = data[c-13];
      else                   bus.ser_in = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid");
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) we_cnt++;
      bus.ser_in = 1'($urandom);
    end
    check_output("reset_mid.we_count", 32'(we_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_func  = 3'b000;
    bus.ser_in    = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    $display("[TB] misalign trap build = %0d", TRAP);

    apply_stimulus("st_word",   1'b1, 3'b010, 12'h010, 32'hDEADBEEF);
    apply_stimulus("st_byte",   1'b1, 3'b000, 12'h013, 32'h000000A5);
    apply_stimulus("st_word0",  1'b1, 3'b010, 12'h000, 32'h00801234);
    apply_stimulus("ld_sbyte",  1'b0, 3'b000, 12'h002, 32'h0);
    apply_stimulus("st_word0b", 1'b1, 3'b010, 12'h000, 32'h80001234);
    apply_stimulus("ld_uhalf",  1'b0, 3'b101, 12'h002, 32'h0);
    apply_stimulus("ld_shalf",  1'b0, 3'b001, 12'h002, 32'h0);
    apply_stimulus("st_word1",  1'b1, 3'b010, 12'h004, 32'h13579BDF);
    apply_stimulus("ld_misw",   1'b0, 3'b010, 12'h006, 32'h0);
    apply_stimulus("ld_after",  1'b0, 3'b011, 12'h004, 32'h0);
    apply_stimulus("st_mish",   1'b1, 3'b001, 12'h011, 32'h0000BEEF);
    apply_stimulus("ld_word4",  1'b0, 3'b010, 12'h010, 32'h0);
    apply_stimulus("ld_ubyte",  1'b0, 3'b100, 12'h013, 32'h0);
    apply_stimulus("ld_high",   1'b0, 3'b010, 12'hFFC, 32'h0);

    apply_reset_mid_store(12'h020, 32'hCAFEF00D);
    apply_stimulus("after_rst_ld", 1'b0, 3'b010, 12'h020, 32'h0);
    apply_stimulus("after_rst_st", 1'b1, 3'b001, 12'h022, 32'h00005AA5);
    apply_stimulus("after_rst_ld2", 1'b0, 3'b010, 12'h020, 32'h0);

    for (int n = 0; n < 40; n++) begin
      logic [11:0] a;
      a = 12'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = a | 12'hFE0;
      apply_stimulus("rand", 1'($urandom), 3'($urandom), a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
